// File: rtl/dff_shift_reg.sv
// WIDTH-bit capture-enabled register with load, shift, rotate, arithmetic shift and clear.
// q, qn, shift_out and zero are all registered so they change together on one edge.
module dff_shift_reg #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cp,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sl_in,
  input  logic             sr_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             shift_out,
  output logic             zero
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_ASR  = 3'b110,
    M_CLR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_nxt;
  logic             so_nxt;

  always_comb begin
    q_nxt  = q;
    so_nxt = shift_out;
    case (mode_e'(mode))
      M_HOLD: ;
      M_LOAD: q_nxt = d;
      M_SHL: begin
        q_nxt  = {q[WIDTH-2:0], sl_in};
        so_nxt = q[WIDTH-1];
      end
      M_SHR: begin
        q_nxt  = {sr_in, q[WIDTH-1:1]};
        so_nxt = q[0];
      end
      M_ROL: begin
        q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
        so_nxt = q[WIDTH-1];
      end
      M_ROR: begin
        q_nxt  = {q[0], q[WIDTH-1:1]};
        so_nxt = q[0];
      end
      M_ASR: begin
        q_nxt  = {q[WIDTH-1], q[WIDTH-1:1]};
        so_nxt = q[0];
      end
      M_CLR: begin
        q_nxt  = '0;
        so_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // qn and zero are derived from the next value so they land with q, not after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= RESET_VAL;
      qn        <= ~RESET_VAL;
      shift_out <= 1'b0;
      zero      <= (RESET_VAL == '0);
    end else if (cp) begin
      q         <= q_nxt;
      qn        <= ~q_nxt;
      shift_out <= so_nxt;
      zero      <= (q_nxt == '0);
    end
  end

endmodule

// File: doc/dff_shift_reg.md
Name: dff_shift_reg

Overview:
- Parametrised successor to the single-bit enabled D flip-flop (ports clk, cp, d, q, qn).
- Generalises it to a WIDTH-bit register with a capture enable and eight operating modes: hold, parallel load, logical shifts, rotates, arithmetic shift and synchronous clear.
- Also provides a registered shifted-out bit and a registered zero flag.
- Used as the general-purpose storage/shift element in the datapath lab designs (accumulator, shift-add multiplier, serial I/O).

Parameters:
WIDTH, 8, register width in bits; legal range 2..64.
RESET_VAL, 0 (WIDTH bits), value loaded into q on asynchronous reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
cp  input  1  capture enable; the register updates only on a rising clk edge with cp=1.
mode  input  3  operation select; sampled only when cp=1.
d  input  WIDTH  parallel load data.
sl_in  input  1  serial input shifted into bit 0 on a left shift.
sr_in  input  1  serial input shifted into bit WIDTH-1 on a right shift.
q  output  WIDTH  register contents.
qn  output  WIDTH  bitwise complement of q, always equal to ~q.
shift_out  output  1  bit expelled by the last shift or rotate.
zero  output  1  1 when q == 0.

Behaviour:
- Reset, while rst_n=0, asynchronous and regardless of clk or cp:
  - q=RESET_VAL, qn=~RESET_VAL
  - shift_out=0
  - zero=(RESET_VAL==0)
- Release of rst_n is synchronised by the system; the first update can occur on the first rising edge after rst_n=1.
- Update rule: on a rising clk edge with rst_n=1 and cp=1, the new q is selected by mode. With cp=0, all outputs hold.
- Modes (b = WIDTH-1):
  - 000 HOLD: q unchanged; shift_out unchanged.
  - 001 LOAD: q=d; shift_out unchanged.
  - 010 SHL: q={q[b-1:0],sl_in}; shift_out=q[b].
  - 011 SHR: q={sr_in,q[b:1]}; shift_out=q[0].
  - 100 ROL: q={q[b-1:0],q[b]}; shift_out=q[b].
  - 101 ROR: q={q[0],q[b:1]}; shift_out=q[0].
  - 110 ASR: q={q[b],q[b:1]}; shift_out=q[0].
  - 111 CLR: q=0; shift_out=0.
- Latency: one cycle. New q, qn, shift_out and zero are all visible after the same edge.
- zero and qn are registered alongside q, not decoded combinationally from q, so all four outputs change on the same edge with no glitches.
- zero must always equal (q==0), including after reset and after CLR.
- shift_out always uses the pre-edge value of q.
- Inputs (d, sl_in, sr_in, mode, cp) must be stable around the rising edge; changes between edges have no effect.
- Reset asserted mid-sequence (cp=1 held) overrides immediately; operation resumes from RESET_VAL.
- WIDTH=2 must work for every mode. There is no wrap-around state beyond the data itself.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle after q=8'hA5 -> q=8'h00, qn=8'hFF, shift_out=0, zero=1 immediately, before the next edge.
- Load/enable: cp=1, mode=001, d=8'h3C, one edge -> q=8'h3C, qn=8'hC3, zero=0. Then cp=0, d=8'hFF for 3 edges -> q stays 8'h3C.
- Logical shifts: q=8'h81, SHL with sl_in=1 -> q=8'h03, shift_out=1. Then SHR with sr_in=0 -> q=8'h01, shift_out=1.
- Rotates: q=8'h81, ROL -> q=8'h03, shift_out=1. Then ROR twice -> q=8'h81 then q=8'hC0.
- Arithmetic shift: q=8'h80, ASR three times -> 8'hC0, 8'hE0, 8'hF0, shift_out=0 each time. Then CLR -> q=0, zero=1, shift_out=0.
- WIDTH=2 instance: load 2'b10, ROL -> 2'b01, ASR -> 2'b00, zero=1.
